aes_ct_serializer: RTL and testbench

Output stage placed directly downstream of the pipelined `aes_top` AES-128 encryptor. It tracks which pipeline slots carry real blocks, captures each valid 128-bit `cryptokey` result into a small block FIFO, and streams it out as four 32-bit words over a valid/ready handshake. It lets the encryptor run at one block per cycle in bursts while the consumer drains at one word per cycle.

---
 rtl/aes_ser_pkg.sv | 19 +
 rtl/aes_ser_fifo.sv | 54 +++++
 rtl/aes_ct_serializer.sv | 174 +++++++++++++++++
 tb/tb_aes_ct_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ser_pkg.sv
// aes_ser_pkg
// Shared types and constants for the AES ciphertext serializer.
//   BLK_W / WORD_W / WORDS_PER_BLK : block and output word geometry
//   ser_state_t                    : serializer FSM state encoding
//   blk_t                          : one 128-bit cipher block
package aes_ser_pkg;

  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic [BLK_W-1:0] blk_t;

endpackage

// File: rtl/aes_ser_fifo.sv
// aes_ser_fifo
// DEPTH x 128-bit block FIFO. The head entry is visible on rdata
// without a read strobe, so the serializer can walk its words in place.
// Storage is not reset; only the pointers are.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (pointers only)
//   push   : write wdata at the tail (caller guarantees room, or a same-edge pop)
//   wdata  : block to store
//   pop    : discard the head entry (caller guarantees non-empty)
//   rdata  : current head block
//   count  : occupied entries, 0..DEPTH
module aes_ser_fifo
  import aes_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [BLK_W-1:0]       wdata,
  input  logic                   pop,
  output logic [BLK_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  blk_t        mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  // Pointers carry one wrap bit so full and empty are distinguishable
  // and the occupancy falls out of a plain subtraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // When full, a push only happens together with a pop, so the write lands
  // in the slot being vacated and the head seen this cycle is unaffected.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];
  assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer
// Sits after the pipelined AES-128 core. Tracks which pipeline slots hold
// real blocks, captures those results into a block FIFO and streams each
// block out as four 32-bit words (most significant word first) over a
// valid/ready handshake.
// Build option: define AES_SER_DROP_CNT_EN to add the saturating drop_cnt
// output; without it only the sticky overflow flag reports drops.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : real block presented to the AES core this cycle
//   cryptokey  : AES core output, sampled LATENCY cycles after in_valid
//   out_data   : current output word (0 when out_valid is low)
//   out_valid  : out_data holds a word
//   out_ready  : consumer accepts the word
//   out_last   : fourth word of a block
//   overflow   : sticky, a result was dropped on a full FIFO
//   fifo_count : occupied FIFO entries
//   drop_cnt   : (option) dropped results, saturating at 255
module aes_ct_serializer
  import aes_ser_pkg::*;
#(
  parameter int LATENCY = 11,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BLK_W-1:0]       cryptokey,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef AES_SER_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLK - 1);

  logic [LATENCY-1:0] vld_sr_reg;
  logic               capture;
  logic               accept;
  logic               pop;
  logic               push;
  logic               drop;
  logic [1:0]         idx_reg;
  logic [1:0]         idx_next;
  ser_state_t         state_reg;
  ser_state_t         state_next;
  logic               send_valid;
  logic               overflow_reg;
  logic [BLK_W-1:0]   head;
  logic [WORD_W-1:0]  head_word [WORDS_PER_BLK];

  // ------------------------------------------------------------------
  // Slot tracking: bit k set means the block sampled k+1 edges ago was
  // real, so the top bit marks the edge its ciphertext appears.
  // ------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_sr_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_sr_reg <= '0;
        else        vld_sr_reg <= in_valid;
      end
    end else begin : g_sr_multi
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_sr_reg <= '0;
        else        vld_sr_reg <= {vld_sr_reg[LATENCY-2:0], in_valid};
      end
    end
  endgenerate

  assign capture = vld_sr_reg[LATENCY-1];

  // A full FIFO still takes the new block if the head leaves on this edge.
  assign accept = (state_reg == SEND) && out_ready;
  assign pop    = accept && (idx_reg == LAST_IDX);
  assign push   = capture && ((fifo_count < CW'(DEPTH)) || pop);
  assign drop   = capture && !push;

  aes_ser_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (cryptokey),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  // Word 0 is the most significant slice of the block.
  generate
    for (genvar gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_word
      assign head_word[gi] = head[BLK_W-1-gi*WORD_W -: WORD_W];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Serializer FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    send_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_count != '0) state_next = SEND;
      end
      SEND: begin
        send_valid = 1'b1;
        if (accept) begin
          // Two-bit index wraps to 0 after the last word by itself.
          idx_next = idx_reg + 2'd1;
          if (idx_reg == LAST_IDX) begin
            // Keep streaming if anything is left after the pop, counting a
            // block captured on the same edge, so back-to-back blocks
            // leave no bubble.
            if ((fifo_count > CW'(1)) || push) state_next = SEND;
            else                               state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // idx and the head only move on acceptance, which keeps the word stable
  // under backpressure.
  assign out_valid = send_valid;
  assign out_data  = send_valid ? head_word[idx_reg] : '0;
  assign out_last  = send_valid && (idx_reg == LAST_IDX);

  // ------------------------------------------------------------------
  // Drop reporting
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow_reg <= 1'b0;
    else if (drop) overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;

`ifdef AES_SER_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hff)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
`timescale 1ns/1ps
module tb_aes_ct_serializer;
  import aes_ser_pkg::*;

  localparam int LAT   = 11;
  localparam int DEPTH = 4;
  localparam logic [127:0] K1 = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] K2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] cryptokey = '0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         overflow;
  logic [2:0]   fifo_count;
`ifdef AES_SER_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  aes_ct_serializer #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .cryptokey  (cryptokey),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .fifo_count (fifo_count)
`ifdef AES_SER_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit v; logic [127:0] key; } slot_t;
  typedef struct { int due; logic [127:0] key; } due_t;
  typedef struct { logic [31:0] data; bit last; } word_t;

  slot_t        m_hist[$];  // model: slots in flight through the AES core
  logic [127:0] mkey_q[$];  // keys handed to the model, one per in_valid
  due_t         drv_q[$];   // driver: when each ciphertext must appear
  word_t        exp_q[$];   // scoreboard: expected output words in order

  int m_cnt  = 0;
  int m_widx = 0;
  int m_drop = 0;
  bit m_pres = 0;
  bit m_ovf  = 0;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ------------------------------------------------------------------
  // Reference model, evaluated at each rising edge on the values the DUT
  // samples there. Blocks appear LAT edges after their slot, land in a
  // DEPTH-deep queue unless it is full and the head is not leaving, and
  // are presented once the queue has been non-empty for a whole cycle.
  // ------------------------------------------------------------------
  always @(posedge clk) begin : model
    slot_t        e;
    bit           cap;
    logic [127:0] ck;
    bit           pop;
    bit           was_ne;
    word_t        x;
    if (!reset) begin
      m_hist.delete();
      exp_q.delete();
      m_cnt  = 0;
      m_widx = 0;
      m_drop = 0;
      m_pres = 0;
      m_ovf  = 0;
      if (in_valid && mkey_q.size() > 0) void'(mkey_q.pop_front());
    end else begin
      cap = 0;
      ck  = '0;
      if (m_hist.size() == LAT) begin
        e   = m_hist.pop_front();
        cap = e.v;
        ck  = e.key;
      end
      e.v   = in_valid;
      e.key = '0;
      if (in_valid && mkey_q.size() > 0) e.key = mkey_q.pop_front();
      m_hist.push_back(e);

      pop = m_pres && out_ready && (m_widx == 3);
      if (m_pres && out_ready) m_widx = (m_widx + 1) % 4;
      was_ne = (m_cnt > 0);
      if (pop) m_cnt--;
      if (cap) begin
        if (m_cnt < DEPTH) begin
          m_cnt++;
          for (int w = 0; w < 4; w++) begin
            x.data = ck[127-32*w -: 32];
            x.last = (w == 3);
            exp_q.push_back(x);
          end
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_pres = was_ne && (m_cnt > 0);
    end
  end

  // ------------------------------------------------------------------
  // Monitor: compares on the falling edge, pops the scoreboard on accept.
  // ------------------------------------------------------------------
  bit          p_stall = 0;
  logic [31:0] p_data  = '0;
  bit          p_last  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_fifo_count", fifo_count, 0);
`ifdef AES_SER_DROP_CNT_EN
      chk("rst_drop_cnt", drop_cnt, 0);
`endif
      p_stall = 0;
    end else begin
      chk("fifo_count", fifo_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("out_valid", out_valid, m_pres);
`ifdef AES_SER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, m_drop);
`endif
      if (p_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, p_data);
        chk("hold_last", out_last, p_last);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 'x);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_last", out_last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_last  = out_last;
    end
  end

  // One clock of stimulus: inputs set here are sampled at edge cyc+1.
  task automatic step(input bit v, input bit r, input logic [127:0] k, input bit rs);
    due_t d;
    @(posedge clk);
    cyc++;
    #1;
    reset     = rs;
    in_valid  = v;
    out_ready = r;
    if (!rs) drv_q.delete();
    while (drv_q.size() > 0 && drv_q[0].due < cyc + 1) void'(drv_q.pop_front());
    if (drv_q.size() > 0 && drv_q[0].due == cyc + 1) begin
      cryptokey = drv_q[0].key;
      void'(drv_q.pop_front());
    end else begin
      cryptokey = rk();  // uncaptured slots carry junk
    end
    if (v) begin
      mkey_q.push_back(k);
      if (rs) begin
        d.due = cyc + 1 + LAT;
        d.key = k;
        drv_q.push_back(d);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset held from time zero.
    repeat (3) step(0, 0, '0, 0);
    repeat (4) step(0, 1, '0, 1);

    // Single block.
    step(1, 1, K1, 1);
    repeat (25) step(0, 1, '0, 1);

    // Back-to-back blocks.
    step(1, 1, K1, 1);
    step(1, 1, K2, 1);
    repeat (25) step(0, 1, '0, 1);

    // Backpressure: word 0 taken, then 5 stalled cycles on word 1.
    step(1, 1, rk(), 1);
    repeat (13) step(0, 1, '0, 1);
    repeat (5) step(0, 0, '0, 1);
    repeat (20) step(0, 1, '0, 1);

    // Full FIFO with the last word accepted on the capture edge.
    repeat (4) step(1, 0, rk(), 1);
    repeat (16) step(0, 0, '0, 1);
    step(1, 0, rk(), 1);
    repeat (7) step(0, 0, '0, 1);
    repeat (4) step(0, 1, '0, 1);
    step(0, 1, '0, 1);
    #1;
    chk("passthru_fifo_count", fifo_count, 4);
    chk("passthru_overflow", overflow, 0);
    repeat (30) step(0, 1, '0, 1);

    // Overflow: 6 blocks into a 4-deep FIFO with no consumer.
    repeat (6) step(1, 0, rk(), 1);
    repeat (12) step(0, 0, '0, 1);
    #1;
    chk("ovf_fifo_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
`ifdef AES_SER_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 2);
`endif
    repeat (30) step(0, 1, '0, 1);

    // Reset mid-stream: word 2 pending, 3 blocks held, 2 more in flight.
    repeat (3) step(1, 0, rk(), 1);
    repeat (12) step(0, 0, '0, 1);
    repeat (2) step(0, 1, '0, 1);
    step(1, 0, rk(), 1);
    step(1, 0, rk(), 1);
    step(0, 0, '0, 0);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_overflow", overflow, 0);
    repeat (2) step(0, 0, '0, 0);
    repeat (30) step(0, 1, '0, 1);

    // Randomized traffic with random backpressure.
    repeat (400) step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rk(), 1);
    repeat (60) step(0, 1, '0, 1);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
